// File: rtl/shift_exmem_if.sv
// EX->MEM pipeline bundle: incoming EX fields with stall/flush, the registered MEM copies,
// and the architectural flag outputs.
interface shift_exmem_if #(
   parameter int DATA_W = 16,
   parameter int REG_W  = 4
);
   logic              ex_valid;
   logic [DATA_W-1:0] ex_result;
   logic              ex_ovfl;
   logic [2:0]        ex_flag_en;
   logic [REG_W-1:0]  ex_dst_reg;
   logic              ex_reg_write;
   logic              ex_mem_read;
   logic              ex_mem_write;
   logic [DATA_W-1:0] ex_store_data;
   logic              stall;
   logic              flush;

   logic              mem_valid;
   logic [DATA_W-1:0] mem_result;
   logic [REG_W-1:0]  mem_dst_reg;
   logic              mem_reg_write;
   logic              mem_mem_read;
   logic              mem_mem_write;
   logic [DATA_W-1:0] mem_store_data;
   logic [2:0]        flags;
   logic [2:0]        flags_fwd;

   modport master (
      output ex_valid, ex_result, ex_ovfl, ex_flag_en, ex_dst_reg, ex_reg_write,
             ex_mem_read, ex_mem_write, ex_store_data, stall, flush,
      input  mem_valid, mem_result, mem_dst_reg, mem_reg_write, mem_mem_read,
             mem_mem_write, mem_store_data, flags, flags_fwd
   );

   modport slave (
      input  ex_valid, ex_result, ex_ovfl, ex_flag_en, ex_dst_reg, ex_reg_write,
             ex_mem_read, ex_mem_write, ex_store_data, stall, flush,
      output mem_valid, mem_result, mem_dst_reg, mem_reg_write, mem_mem_read,
             mem_mem_write, mem_store_data, flags, flags_fwd
   );
endinterface

// File: rtl/shift_exmem_stage.sv
// EX/MEM pipeline register for the shift/ALU path, with the {Z,V,N} flag register and a
// combinational forward of next-cycle flags for branch resolution in the same cycle.
module shift_exmem_stage #(
   parameter int DATA_W = 16,
   parameter int REG_W  = 4
) (
   input logic          clk,
   input logic          rst,
   shift_exmem_if.slave bus
);
   logic       cap;
   logic [2:0] flag_cand;
   logic [2:0] flags_next;

   assign cap       = !bus.stall && !bus.flush && bus.ex_valid;
   assign flag_cand = {(bus.ex_result == '0), bus.ex_ovfl, bus.ex_result[DATA_W-1]};

   // NOTE: flags_next is given its hold value first so no path leaves it unassigned (no latch).
   always_comb begin
      flags_next = bus.flags;
      if (rst) begin
         flags_next = '0;
      end else if (cap) begin
         for (int i = 0; i < 3; i++) begin
            if (bus.ex_flag_en[i]) flags_next[i] = flag_cand[i];
         end
      end
   end

   assign bus.flags_fwd = flags_next;

   // NOTE: non-blocking assignments throughout so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         bus.mem_valid      <= 1'b0;
         bus.mem_result     <= '0;
         bus.mem_dst_reg    <= '0;
         bus.mem_reg_write  <= 1'b0;
         bus.mem_mem_read   <= 1'b0;
         bus.mem_mem_write  <= 1'b0;
         bus.mem_store_data <= '0;
         bus.flags          <= '0;
      end else if (bus.flush) begin
         // Bubble: control cleared, data fields left as they were, flags untouched.
         bus.mem_valid     <= 1'b0;
         bus.mem_reg_write <= 1'b0;
         bus.mem_mem_read  <= 1'b0;
         bus.mem_mem_write <= 1'b0;
      end else if (!bus.stall) begin
         bus.mem_valid      <= bus.ex_valid;
         bus.mem_result     <= bus.ex_result;
         bus.mem_dst_reg    <= bus.ex_dst_reg;
         bus.mem_reg_write  <= bus.ex_reg_write & bus.ex_valid;
         bus.mem_mem_read   <= bus.ex_mem_read  & bus.ex_valid;
         bus.mem_mem_write  <= bus.ex_mem_write & bus.ex_valid;
         bus.mem_store_data <= bus.ex_store_data;
         bus.flags          <= flags_next;
      end
   end
endmodule

// File: tb/tb_shift_exmem_stage.sv
// Randomized scoreboard bench for shift_exmem_stage: the driver pushes expected MEM-side state
// per edge, a monitor pops and compares after each rising edge.
module tb_shift_exmem_stage;
   localparam int DATA_W = 16;
   localparam int REG_W  = 4;

   typedef struct {
      logic              valid, rw, mr, mw, known;
      logic [DATA_W-1:0] result, sd;
      logic [REG_W-1:0]  dst;
      logic [2:0]        flags;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_pass = 0;
   int   n_total = 0;
   exp_t exp_q[$];
   exp_t m;  // reference state of the stage as seen after the last edge

   shift_exmem_if #(.DATA_W(DATA_W), .REG_W(REG_W)) bus ();
   shift_exmem_stage #(.DATA_W(DATA_W), .REG_W(REG_W)) dut (.clk(clk), .rst(rst), .bus(bus));

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
   endtask

   // Drive one cycle of stimulus, check the forwarded flags, and queue the post-edge state.
   task automatic step(input logic r, input logic v, input logic [DATA_W-1:0] res,
                       input logic ovfl, input logic [2:0] fe, input logic [REG_W-1:0] dst,
                       input logic rw, input logic mr, input logic mw,
                       input logic [DATA_W-1:0] sd, input logic st, input logic fl);
      logic [2:0] cand, nf;
      @(negedge clk);
      rst = r;
      bus.ex_valid = v;  bus.ex_result = res; bus.ex_ovfl = ovfl; bus.ex_flag_en = fe;
      bus.ex_dst_reg = dst; bus.ex_reg_write = rw; bus.ex_mem_read = mr; bus.ex_mem_write = mw;
      bus.ex_store_data = sd; bus.stall = st; bus.flush = fl;
      #1;
      cand = {res == 0, ovfl, res[DATA_W-1]};
      nf = m.flags;
      if (!st && !fl && v) nf = (m.flags & ~fe) | (cand & fe);
      if (r) nf = 3'b000;
      check("flags_fwd", 32'(bus.flags_fwd), 32'(nf));
      if (r) begin
         m = '{valid: 0, rw: 0, mr: 0, mw: 0, known: 1, result: 0, sd: 0, dst: 0, flags: 0};
      end else if (fl) begin
         m.valid = 0; m.rw = 0; m.mr = 0; m.mw = 0; m.known = 0;
      end else if (!st) begin
         m = '{valid: v, rw: rw && v, mr: mr && v, mw: mw && v, known: 1,
               result: res, sd: sd, dst: dst, flags: nf};
      end
      exp_q.push_back(m);
   endtask

   // Monitor: every rising edge presents a new MEM-side state.
   always @(posedge clk) begin
      exp_t e;
      #1;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         check("mem_valid", 32'(bus.mem_valid), 32'(e.valid));
         check("mem_reg_write", 32'(bus.mem_reg_write), 32'(e.rw));
         check("mem_mem_read", 32'(bus.mem_mem_read), 32'(e.mr));
         check("mem_mem_write", 32'(bus.mem_mem_write), 32'(e.mw));
         check("flags", 32'(bus.flags), 32'(e.flags));
         if (e.known) begin
            check("mem_result", 32'(bus.mem_result), 32'(e.result));
            check("mem_dst_reg", 32'(bus.mem_dst_reg), 32'(e.dst));
            check("mem_store_data", 32'(bus.mem_store_data), 32'(e.sd));
         end
      end
   end

   task automatic after_edge;
      @(posedge clk);
      #2;
   endtask

   initial begin
      logic [DATA_W-1:0] res;
      m = '{valid: 0, rw: 0, mr: 0, mw: 0, known: 0, result: 0, sd: 0, dst: 0, flags: 0};
      bus.ex_valid = 0; bus.ex_result = 0; bus.ex_ovfl = 0; bus.ex_flag_en = 0;
      bus.ex_dst_reg = 0; bus.ex_reg_write = 0; bus.ex_mem_read = 0; bus.ex_mem_write = 0;
      bus.ex_store_data = 0; bus.stall = 0; bus.flush = 0;

      // Reset with a live instruction on the inputs.
      step(1, 1, 16'h1234, 1, 3'b111, 4'hA, 1, 1, 1, 16'hBEEF, 0, 0);
      after_edge();
      check("rst_mem_result", 32'(bus.mem_result), 32'h0);
      check("rst_flags", 32'(bus.flags), 32'h0);

      // Arithmetic: 0x8000 with overflow -> {Z,V,N} = 011.
      step(0, 1, 16'h8000, 1, 3'b111, 4'h3, 1, 0, 0, 16'h0, 0, 0);
      after_edge();
      check("arith_flags", 32'(bus.flags), 32'b011);
      check("arith_result", 32'(bus.mem_result), 32'h8000);

      // Shift writing only Z on a zero result: 011 -> 111, forwarded in the capture cycle.
      step(0, 1, 16'h0000, 0, 3'b100, 4'h4, 1, 0, 0, 16'h0, 0, 0);
      check("shift_fwd", 32'(bus.flags_fwd), 32'b111);
      after_edge();
      check("shift_flags", 32'(bus.flags), 32'b111);

      // Capture 0x00F0 then stall three cycles with different inputs.
      step(0, 1, 16'h00F0, 0, 3'b000, 4'h5, 1, 0, 0, 16'h1111, 0, 0);
      for (int i = 0; i < 3; i++)
         step(0, 1, 16'h0F00 + 16'(i), 1, 3'b111, 4'h6, 1, 1, 0, 16'h2222, 1, 0);
      after_edge();
      check("stall_result", 32'(bus.mem_result), 32'h00F0);
      check("stall_flags", 32'(bus.flags), 32'b111);

      // Flush beats stall.
      step(0, 1, 16'h0000, 1, 3'b111, 4'h7, 1, 0, 0, 16'h0, 1, 1);
      after_edge();
      check("flush_valid", 32'(bus.mem_valid), 32'h0);
      check("flush_reg_write", 32'(bus.mem_reg_write), 32'h0);
      check("flush_flags", 32'(bus.flags), 32'b111);

      // Bubble with a stray store bit.
      step(0, 0, 16'h8000, 1, 3'b111, 4'h8, 0, 0, 1, 16'h3333, 0, 0);
      after_edge();
      check("bubble_valid", 32'(bus.mem_valid), 32'h0);
      check("bubble_mem_write", 32'(bus.mem_mem_write), 32'h0);
      check("bubble_flags", 32'(bus.flags), 32'b111);

      // Reset asserted during a stall clears held state.
      step(0, 1, 16'h4321, 0, 3'b111, 4'h9, 1, 1, 1, 16'h4444, 0, 0);
      step(1, 1, 16'h5555, 0, 3'b111, 4'h9, 1, 1, 1, 16'h5555, 1, 0);
      after_edge();
      check("rst_stall_result", 32'(bus.mem_result), 32'h0);
      check("rst_stall_valid", 32'(bus.mem_valid), 32'h0);

      // Randomized traffic with biased corner values.
      for (int i = 0; i < 600; i++) begin
         case ($urandom_range(0, 5))
            0:       res = 16'h0000;
            1:       res = 16'h8000;
            default: res = 16'($urandom);
         endcase
         step($urandom_range(0, 49) == 0, $urandom_range(0, 3) != 0, res,
              1'($urandom), 3'($urandom), 4'($urandom), 1'($urandom), 1'($urandom),
              1'($urandom), 16'($urandom), $urandom_range(0, 4) == 0,
              $urandom_range(0, 7) == 0);
      end

      for (int i = 0; i < 10 && exp_q.size() > 0; i++) after_edge();
      check("scoreboard_drained", 32'(exp_q.size()), 32'h0);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
